// File: rtl/screen_comp_pkg.sv
// Shared encodings for the screen compositor: per-layer display modes,
// the alarm FSM state type and a helper that decides whether a layer's
// mode lets it show in the current blink/alarm phase.
package screen_comp_pkg;

  // Two-bit per-layer display mode carried in LAYER_MODE[2k +: 2].
  localparam logic [1:0] MODE_ALWAYS = 2'b00;
  localparam logic [1:0] MODE_FAST   = 2'b01;
  localparam logic [1:0] MODE_ALARM  = 2'b10;
  localparam logic [1:0] MODE_OFF    = 2'b11;

  typedef enum logic {
    ALARM_IDLE    = 1'b0,
    ALARM_RINGING = 1'b1
  } alarm_state_t;

  // True when a layer in the given mode may be shown this cycle.
  function automatic logic mode_allows(input logic [1:0] mode,
                                       input logic       fast,
                                       input logic       ringing);
    logic ok;
    case (mode)
      MODE_ALWAYS: ok = 1'b1;
      MODE_FAST:   ok = fast;
      MODE_ALARM:  ok = ringing & fast;
      default:     ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/screen_compositor_blink_divider.sv
// Free-running blink divider: counts 0..DIV-1 on every clock, wraps to 0
// and flips the phase on the DIV-1 cycle. toggle is high during the cycle
// whose closing edge flips the phase.
module blink_divider #(
  parameter int DIV = 4
) (
  input  logic clock,
  input  logic reset,
  output logic phase,
  output logic toggle
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  assign toggle = (count == LAST);

  // Counter and phase advance every clock, independent of pixel enable.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
      phase <= 1'b0;
    end else if (toggle) begin
      count <= '0;
      phase <= ~phase;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/screen_compositor.sv
// Screen compositor: priority-muxes NUM_LAYERS overlay layers (layer 0
// wins) into a registered pixel, with fast/slow blink phases and an
// alarm FSM that makes MODE_ALARM layers flash until acknowledged or
// until RING_TOGGLES slow-blink toggles have passed.
// Optional build macro SCREEN_COMP_BG_COLOR_EN adds a bg_color input used
// as the background colour; without it the background is all zeros.
// Handshake note: there is no valid/ready traffic here; pixel_tick is a
// plain enable, rgb holds between ticks, alarm_req is a level whose rising
// edge arms the alarm and alarm_ack is sampled every clock.
// RING_TOGGLES is assumed to be at least 1.
module screen_compositor
  import screen_comp_pkg::*;
#(
  parameter int NUM_LAYERS   = 4,
  parameter int RGB_W        = 12,
  parameter int FAST_DIV     = 16666667,
  parameter int SLOW_DIV     = 25000000,
  parameter int RING_TOGGLES = 30,
  parameter logic [2*NUM_LAYERS-1:0] LAYER_MODE = '0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        pixel_tick,
  input  logic                        video_on,
  input  logic [NUM_LAYERS-1:0]       layer_on,
  input  logic [NUM_LAYERS-1:0]       layer_gate,
  input  logic [NUM_LAYERS*RGB_W-1:0] layer_rgb,
  input  logic                        alarm_req,
  input  logic                        alarm_ack,
`ifdef SCREEN_COMP_BG_COLOR_EN
  input  logic [RGB_W-1:0]            bg_color,
`endif
  output logic [RGB_W-1:0]            rgb,
  output logic                        alarm_active,
  output logic                        blink_fast,
  output logic                        blink_slow
);

  localparam int TW = $clog2(RING_TOGGLES + 1);
  localparam logic [TW-1:0] LAST_TOG = TW'(RING_TOGGLES - 1);

  logic         fast_toggle;
  logic         slow_toggle;
  alarm_state_t state;
  alarm_state_t state_next;
  logic [TW-1:0] tog_cnt;
  logic [TW-1:0] tog_next;
  logic         req_q;
  logic         req_rise;
  logic [RGB_W-1:0] bg;
  logic [RGB_W-1:0] pix_next;
  logic         found;

  blink_divider #(.DIV(FAST_DIV)) u_fast (
    .clock  (clock),
    .reset  (reset),
    .phase  (blink_fast),
    .toggle (fast_toggle)
  );

  blink_divider #(.DIV(SLOW_DIV)) u_slow (
    .clock  (clock),
    .reset  (reset),
    .phase  (blink_slow),
    .toggle (slow_toggle)
  );

`ifdef SCREEN_COMP_BG_COLOR_EN
  assign bg = bg_color;
`else
  assign bg = '0;
`endif

  assign req_rise     = alarm_req & ~req_q;
  assign alarm_active = (state == ALARM_RINGING);

  // Alarm state, toggle counter and alarm_req edge register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ALARM_IDLE;
      tog_cnt <= '0;
      req_q   <= 1'b0;
    end else begin
      state   <= state_next;
      tog_cnt <= tog_next;
      req_q   <= alarm_req;
    end
  end

  // Alarm next state: a rising edge arms even with ack high; once ringing,
  // ack beats a restart edge, and a restart edge beats a slow toggle.
  always_comb begin
    state_next = state;
    tog_next   = tog_cnt;
    case (state)
      ALARM_IDLE: begin
        if (req_rise) begin
          state_next = ALARM_RINGING;
          tog_next   = '0;
        end
      end
      ALARM_RINGING: begin
        if (alarm_ack) begin
          state_next = ALARM_IDLE;
          tog_next   = '0;
        end else if (req_rise) begin
          tog_next = '0;
        end else if (slow_toggle) begin
          if (tog_cnt == LAST_TOG) begin
            state_next = ALARM_IDLE;
            tog_next   = '0;
          end else begin
            tog_next = tog_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_next = ALARM_IDLE;
        tog_next   = '0;
      end
    endcase
  end

  // Priority mux: lowest-index eligible layer wins, blanked outside video.
  always_comb begin
    pix_next = bg;
    found    = 1'b0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      if (!found && layer_on[k] && layer_gate[k] &&
          mode_allows(LAYER_MODE[2*k +: 2], blink_fast, alarm_active)) begin
        pix_next = layer_rgb[k*RGB_W +: RGB_W];
        found    = 1'b1;
      end
    end
    if (!video_on) begin
      pix_next = '0;
    end
  end

  // Output pixel register, loaded only on pixel enable.
  always_ff @(posedge clock) begin
    if (reset) begin
      rgb <= '0;
    end else if (pixel_tick) begin
      rgb <= pix_next;
    end
  end

endmodule

// File: tb/tb_screen_compositor.sv
// Testbench for screen_compositor with small blink dividers so that blink
// and alarm timing fits in a short run. A behavioural reference model of
// the blink phases and alarm tracks the DUT edge by edge; expected pixels
// are queued when a pixel_tick is driven and popped after the edge.
module tb_screen_compositor;

  localparam int NL = 4;
  localparam int W  = 12;
  localparam int FD = 4;
  localparam int SD = 6;
  localparam int RT = 3;
  // layer3=off, layer2=fast-blink, layer1=always, layer0=alarm
  localparam logic [2*NL-1:0] LM = 8'b11_01_00_10;

  logic          clock;
  logic          reset;
  logic          pixel_tick;
  logic          video_on;
  logic [NL-1:0] layer_on;
  logic [NL-1:0] layer_gate;
  logic [NL*W-1:0] layer_rgb;
  logic          alarm_req;
  logic          alarm_ack;
  logic [W-1:0]  bg_color;
  logic [W-1:0]  rgb;
  logic          alarm_active;
  logic          blink_fast;
  logic          blink_slow;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] hold_rgb;

  // reference model state
  int   cyc;
  int   m_fc, m_sc, m_tog;
  logic m_fast, m_slow, m_ring, m_req_q;

  screen_compositor #(
    .NUM_LAYERS   (NL),
    .RGB_W        (W),
    .FAST_DIV     (FD),
    .SLOW_DIV     (SD),
    .RING_TOGGLES (RT),
    .LAYER_MODE   (LM)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .pixel_tick   (pixel_tick),
    .video_on     (video_on),
    .layer_on     (layer_on),
    .layer_gate   (layer_gate),
    .layer_rgb    (layer_rgb),
    .alarm_req    (alarm_req),
    .alarm_ack    (alarm_ack),
`ifdef SCREEN_COMP_BG_COLOR_EN
    .bg_color     (bg_color),
`endif
    .rgb          (rgb),
    .alarm_active (alarm_active),
    .blink_fast   (blink_fast),
    .blink_slow   (blink_slow)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // reference model of blink phases and alarm behaviour
  always @(posedge clock) begin
    if (reset) begin
      cyc <= 0; m_fc <= 0; m_sc <= 0; m_tog <= 0;
      m_fast <= 1'b0; m_slow <= 1'b0; m_ring <= 1'b0; m_req_q <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (m_fc == FD - 1) begin m_fc <= 0; m_fast <= ~m_fast; end
      else m_fc <= m_fc + 1;
      if (m_sc == SD - 1) begin m_sc <= 0; m_slow <= ~m_slow; end
      else m_sc <= m_sc + 1;
      m_req_q <= alarm_req;
      if (!m_ring) begin
        if (alarm_req && !m_req_q) begin m_ring <= 1'b1; m_tog <= 0; end
      end else if (alarm_ack) begin
        m_ring <= 1'b0;
      end else if (alarm_req && !m_req_q) begin
        m_tog <= 0;
      end else if (m_sc == SD - 1) begin
        if (m_tog + 1 >= RT) m_ring <= 1'b0;
        m_tog <= m_tog + 1;
      end
    end
  end

  function automatic logic [W-1:0] bg_exp();
`ifdef SCREEN_COMP_BG_COLOR_EN
    return bg_color;
`else
    return '0;
`endif
  endfunction

  // expected composite from current inputs and model phases
  function automatic logic [W-1:0] exp_pix();
    logic [W-1:0] r;
    logic [1:0]   md;
    logic         el;
    r = bg_exp();
    for (int k = NL - 1; k >= 0; k--) begin
      md = LM[2*k +: 2];
      el = (md == 2'b00) || (md == 2'b01 && m_fast) ||
           (md == 2'b10 && m_fast && m_ring);
      if (layer_on[k] && layer_gate[k] && el) r = layer_rgb[k*W +: W];
    end
    if (!video_on) r = '0;
    return r;
  endfunction

  // driver: one clock with the given pixel enable; scoreboard pop/compare
  task automatic step(input logic pt);
    logic rw;
    rw = reset;
    pixel_tick = pt;
    if (!rw && pt) exp_q.push_back(exp_pix());
    @(posedge clock);
    #1;
    if (rw) hold_rgb = '0;
    else if (pt) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_empty: rgb=%h, no expected entry", rgb);
      end else hold_rgb = exp_q.pop_front();
    end
    checks++;
    if (rgb !== hold_rgb) begin
      errors++;
      $display("FAIL rgb cyc=%0d: got %h expected %h", cyc, rgb, hold_rgb);
    end
    checks++;
    if (blink_fast !== m_fast || blink_slow !== m_slow) begin
      errors++;
      $display("FAIL blink cyc=%0d: got f=%b s=%b expected f=%b s=%b",
               cyc, blink_fast, blink_slow, m_fast, m_slow);
    end
    checks++;
    if (alarm_active !== m_ring) begin
      errors++;
      $display("FAIL alarm_active cyc=%0d: got %b expected %b", cyc, alarm_active, m_ring);
    end
  endtask

  task automatic set_layer(input int k, input logic [W-1:0] c);
    layer_rgb[k*W +: W] = c;
  endtask

  task automatic do_reset();
    reset = 1'b1; alarm_req = 1'b0; alarm_ack = 1'b0;
    step(1'b0);
    step(1'b0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    layer_on = 4'b1111; layer_gate = 4'b1111; video_on = 1'b1;
    alarm_req = 1'b1; reset = 1'b1;
    step(1'b1);
    step(1'b1);
    checks++;
    if (rgb !== '0 || blink_fast !== 1'b0 || blink_slow !== 1'b0 || alarm_active !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: rgb=%h f=%b s=%b a=%b expected all 0",
               rgb, blink_fast, blink_slow, alarm_active);
    end
    alarm_req = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_blink();
    logic ef, es;
    do_reset();
    layer_on = 4'b0010; layer_gate = 4'b1111; video_on = 1'b1;
    for (int i = 0; i < 13; i++) begin
      step(((cyc + 1) % 4) == 0);
      ef = ((cyc / FD) % 2) == 1;
      es = ((cyc / SD) % 2) == 1;
      checks++;
      if (blink_fast !== ef || blink_slow !== es) begin
        errors++;
        $display("FAIL blink_timing clk=%0d: got f=%b s=%b expected f=%b s=%b",
                 cyc, blink_fast, blink_slow, ef, es);
      end
      checks++;
      if (rgb !== ((cyc < 4) ? 12'h000 : 12'hF00)) begin
        errors++;
        $display("FAIL first_tick clk=%0d: got %h expected %h",
                 cyc, rgb, (cyc < 4) ? 12'h000 : 12'hF00);
      end
    end
  endtask

  task automatic test_priority();
    layer_on = 4'b0110; layer_gate = 4'b1111; video_on = 1'b1;
    step(1'b1);
    checks++;
    if (rgb !== 12'hF00) begin
      errors++;
      $display("FAIL priority: got %h expected F00", rgb);
    end
    video_on = 1'b0;
    step(1'b1);
    checks++;
    if (rgb !== 12'h000) begin
      errors++;
      $display("FAIL video_off: got %h expected 000", rgb);
    end
    video_on = 1'b1;
    step(1'b0);
    step(1'b0);
    layer_gate = 4'b1101;
    for (int i = 0; i < 8; i++) step(1'b1);
    layer_on = 4'b1000;
    step(1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++) begin
      layer_on   = NL'($urandom_range(0, 15));
      layer_gate = NL'($urandom_range(0, 15));
      video_on   = ($urandom_range(0, 5) != 0);
      for (int k = 0; k < NL; k++) set_layer(k, W'($urandom_range(0, 4095)));
      if ($urandom_range(0, 7) == 0) alarm_req = ~alarm_req;
      alarm_ack = ($urandom_range(0, 15) == 0);
      step($urandom_range(0, 1) == 1);
    end
    alarm_req = 1'b0; alarm_ack = 1'b0;
  endtask

  task automatic test_alarm();
    int e;
    do_reset();
    layer_on = 4'b0001; layer_gate = 4'b1111; video_on = 1'b1;
    set_layer(0, 12'h0FF);
    for (int i = 0; i < SD && (cyc % SD) != SD - 1; i++) step(1'b1);
    alarm_req = 1'b1;
    step(1'b1);
    e = cyc;
    checks++;
    if (alarm_active !== 1'b1) begin
      errors++;
      $display("FAIL alarm_arm: got %b expected 1", alarm_active);
    end
    while (cyc < e + 17) step(1'b1);
    checks++;
    if (alarm_active !== 1'b1) begin
      errors++;
      $display("FAIL alarm_hold_17: got %b expected 1", alarm_active);
    end
    step(1'b1);
    checks++;
    if (alarm_active !== 1'b0) begin
      errors++;
      $display("FAIL alarm_autoclear_18: got %b expected 0", alarm_active);
    end
    for (int i = 0; i < 10; i++) step(1'b1);
    checks++;
    if (alarm_active !== 1'b0) begin
      errors++;
      $display("FAIL no_rearm: got %b expected 0", alarm_active);
    end
  endtask

  task automatic test_ack();
    alarm_req = 1'b0; alarm_ack = 1'b1;
    step(1'b1);
    alarm_req = 1'b1;
    step(1'b1);
    checks++;
    if (alarm_active !== 1'b1) begin
      errors++;
      $display("FAIL arm_with_ack: got %b expected 1", alarm_active);
    end
    alarm_req = 1'b0; alarm_ack = 1'b0;
    step(1'b1);
    alarm_req = 1'b1; alarm_ack = 1'b1;
    step(1'b1);
    checks++;
    if (alarm_active !== 1'b0) begin
      errors++;
      $display("FAIL ack_priority: got %b expected 0", alarm_active);
    end
    alarm_ack = 1'b0;
    for (int i = 0; i < 8; i++) step(1'b1);
    // restart: new edge while ringing extends the ring
    alarm_req = 1'b0; step(1'b1);
    alarm_req = 1'b1; step(1'b1);
    for (int i = 0; i < 9; i++) step(1'b1);
    alarm_req = 1'b0; step(1'b1);
    alarm_req = 1'b1;
    for (int i = 0; i < 20; i++) step(1'b1);
  endtask

  task automatic test_reset_mid_ring();
    alarm_req = 1'b0; step(1'b1);
    alarm_req = 1'b1; step(1'b1);
    for (int i = 0; i < 5; i++) step(1'b1);
    reset = 1'b1;
    step(1'b1);
    checks++;
    if (rgb !== '0 || blink_fast !== 1'b0 || blink_slow !== 1'b0 || alarm_active !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_ring: rgb=%h f=%b s=%b a=%b expected all 0",
               rgb, blink_fast, blink_slow, alarm_active);
    end
    reset = 1'b0; alarm_req = 1'b0;
    layer_on = 4'b0000; video_on = 1'b1;
    step(1'b1);
    checks++;
`ifdef SCREEN_COMP_BG_COLOR_EN
    if (rgb !== 12'h00F) begin
      errors++;
      $display("FAIL background: got %h expected 00F", rgb);
    end
`else
    if (rgb !== 12'h000) begin
      errors++;
      $display("FAIL background: got %h expected 000", rgb);
    end
`endif
  endtask

  initial begin
    reset = 1'b1; pixel_tick = 1'b0; video_on = 1'b0;
    layer_on = '0; layer_gate = '0; layer_rgb = '0;
    alarm_req = 1'b0; alarm_ack = 1'b0; bg_color = 12'h00F;
    hold_rgb = '0;
    set_layer(0, 12'h00F);
    set_layer(1, 12'hF00);
    set_layer(2, 12'h0F0);
    set_layer(3, 12'hFFF);
    test_reset();
    test_blink();
    test_priority();
    test_random();
    set_layer(1, 12'hF00);
    set_layer(2, 12'h0F0);
    test_alarm();
    test_ack();
    test_reset_mid_ring();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d entries, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
